// File: rtl/alu_mult_sequencer_if.sv
// Handshake and operand/result bus between the instruction decoder and the
// sequential 5x5 signed matrix-multiply controller.
interface alu_mult_sequencer_if #(
   parameter int DIM = 5,
   parameter int W   = 8
);
   localparam int FLAT = DIM * DIM * W;

   logic            i_start;
   logic            i_abort;
   logic [FLAT-1:0] i_a_flat;
   logic [FLAT-1:0] i_b_flat;
   logic            o_busy;
   logic            o_done;
   logic [FLAT-1:0] o_c_flat;
   logic            o_overflow_flag;

   modport master (
      output i_start, i_abort, i_a_flat, i_b_flat,
      input  o_busy, o_done, o_c_flat, o_overflow_flag
   );

   modport slave (
      input  i_start, i_abort, i_a_flat, i_b_flat,
      output o_busy, o_done, o_c_flat, o_overflow_flag
   );
endinterface

// File: rtl/alu_mult_sequencer.sv
// Sequential C = A*B for 5x5 signed bytes: one shared 5-term dot product,
// one result element per cycle, start/busy/done handshake.
module alu_mult_sequencer #(
   parameter int DIM = 5,
   parameter int W   = 8
) (
   input logic                 i_clk,
   input logic                 i_rst,
   alu_mult_sequencer_if.slave bus
);
   localparam int PW = 2 * W;
   localparam int SW = 2 * W + 2;
   localparam logic [2:0] LAST_IDX = 3'd4;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_COMPUTE = 2'd1,
      S_DONE    = 2'd2
   } state_t;

   state_t r_state;
   state_t w_state_nxt;

   logic [DIM-1:0][DIM-1:0][W-1:0] r_a;
   logic [DIM-1:0][DIM-1:0][W-1:0] r_b;
   logic [DIM-1:0][DIM-1:0][W-1:0] r_c;
   logic                           r_ovf;
   logic [2:0]                     r_row;
   logic [2:0]                     r_col;
   logic                           r_busy;
   logic                           r_done;

   logic                 w_last;
   logic                 w_accept;
   logic                 w_write;
   logic                 w_busy_nxt;
   logic                 w_done_nxt;
   logic signed [PW-1:0] w_prod [DIM];
   logic signed [SW-1:0] w_sum;
   logic                 w_elem_ovf;

   assign w_last = (r_row == LAST_IDX) && (r_col == LAST_IDX);

   // State register.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next state; abort outranks the final-element transition.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (bus.i_start) begin
               w_state_nxt = S_COMPUTE;
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         S_COMPUTE: begin
            if (bus.i_abort) begin
               w_state_nxt = S_IDLE;
            end else if (w_last) begin
               w_state_nxt = S_DONE;
            end else begin
               w_state_nxt = S_COMPUTE;
            end
         end
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Datapath strobes and next values of the registered handshake outputs.
   always_comb begin
      w_accept   = 1'b0;
      w_write    = 1'b0;
      w_busy_nxt = 1'b0;
      w_done_nxt = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_accept = bus.i_start;
         end
         S_COMPUTE: begin
            w_write = ~bus.i_abort;
         end
         S_DONE: begin
            w_accept = 1'b0;
         end
         default: begin
            w_accept = 1'b0;
         end
      endcase
      if (w_state_nxt == S_COMPUTE) begin
         w_busy_nxt = 1'b1;
      end else begin
         w_busy_nxt = 1'b0;
      end
      if (w_state_nxt == S_DONE) begin
         w_done_nxt = 1'b1;
      end else begin
         w_done_nxt = 1'b0;
      end
   end

   // Shared dot product of latched A row r_row and B column r_col; the
   // 18-bit sum cannot wrap, so the range test sees the true value.
   always_comb begin
      w_sum = '0;
      for (int k = 0; k < DIM; k++) begin
         w_prod[k] = $signed(r_a[r_row][3'(k)]) * $signed(r_b[3'(k)][r_col]);
         w_sum     = w_sum + $signed({{2{w_prod[k][PW-1]}}, w_prod[k]});
      end
      w_elem_ovf = (w_sum > 18'sd127) || (w_sum < -18'sd128);
   end

   // Operand capture, element write-back and row-major index sequencing.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_a   <= '0;
         r_b   <= '0;
         r_c   <= '0;
         r_ovf <= 1'b0;
         r_row <= 3'd0;
         r_col <= 3'd0;
      end else if (w_accept) begin
         r_a   <= bus.i_a_flat;
         r_b   <= bus.i_b_flat;
         r_c   <= '0;
         r_ovf <= 1'b0;
         r_row <= 3'd0;
         r_col <= 3'd0;
      end else if (w_write) begin
         r_c[r_row][r_col] <= w_sum[W-1:0];
         r_ovf             <= r_ovf | w_elem_ovf;
         if (r_col == LAST_IDX) begin
            r_col <= 3'd0;
            if (r_row == LAST_IDX) begin
               r_row <= 3'd0;
            end else begin
               r_row <= r_row + 3'd1;
            end
         end else begin
            r_col <= r_col + 3'd1;
         end
      end
   end

   // Registered handshake outputs.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_busy <= 1'b0;
         r_done <= 1'b0;
      end else begin
         r_busy <= w_busy_nxt;
         r_done <= w_done_nxt;
      end
   end

   assign bus.o_busy          = r_busy;
   assign bus.o_done          = r_done;
   assign bus.o_c_flat        = r_c;
   assign bus.o_overflow_flag = r_ovf;
endmodule

// File: tb/tb_alu_mult_sequencer.sv
// Scoreboard bench for alu_mult_sequencer: random and directed multiplies
// against an integer matrix-multiply reference model.
module tb_alu_mult_sequencer;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;
   int   free_at = 0;
   int   busy_run = 0;

   typedef struct {
      logic [199:0] c;
      logic         ovf;
      int           cyc;
   } exp_t;
   exp_t sb_q[$];

   alu_mult_sequencer_if bus ();

   alu_mult_sequencer dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [199:0] act, input logic [199:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference: first n row-major elements of A*B, the rest left zero.
   function automatic void ref_partial(input logic [199:0] a, input logic [199:0] b,
                                       input int n, output logic [199:0] c, output logic ovf);
      int s;
      c   = '0;
      ovf = 1'b0;
      for (int e = 0; e < n; e++) begin
         s = 0;
         for (int k = 0; k < 5; k++)
            s += int'($signed(a[(e/5)*40 + k*8 +: 8])) * int'($signed(b[k*40 + (e%5)*8 +: 8]));
         c[(e/5)*40 + (e%5)*8 +: 8] = s[7:0];
         if (s > 127 || s < -128) ovf = 1'b1;
      end
   endfunction

   function automatic logic [199:0] rand_mat(input int mode);
      logic [199:0] m;
      for (int e = 0; e < 25; e++) begin
         if (mode == 0) m[e*8 +: 8] = 8'($urandom_range(0, 255));
         else           m[e*8 +: 8] = 8'($urandom_range(0, 6)) - 8'd3;
      end
      return m;
   endfunction

   function automatic logic [199:0] fill(input logic [7:0] v);
      logic [199:0] m;
      for (int e = 0; e < 25; e++) m[e*8 +: 8] = v;
      return m;
   endfunction

   // One clock of stimulus; a start the model says is accepted queues its result.
   task automatic step(input logic st, input logic [199:0] a, input logic [199:0] b);
      logic [199:0] c;
      logic         o;
      bus.i_start  = st;
      bus.i_abort  = 1'b0;
      bus.i_a_flat = a;
      bus.i_b_flat = b;
      @(posedge clk);
      #1;
      if (st && cyc >= free_at) begin
         ref_partial(a, b, 25, c, o);
         sb_q.push_back('{c: c, ovf: o, cyc: cyc + 25});
         free_at = cyc + 27;
      end
   endtask

   task automatic drain();
      int n = 0;
      while (sb_q.size() != 0 && n < 200) begin
         step(1'b0, rand_mat(0), rand_mat(0));
         n++;
      end
      chk("drain_timeout", 200'(sb_q.size()), 200'd0);
      step(1'b0, '0, '0);
      step(1'b0, '0, '0);
   endtask

   // Monitor: pops the scoreboard on every done pulse.
   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         busy_run = 0;
      end else begin
         if (bus.o_busy && bus.o_done) chk("busy_and_done", 200'd1, 200'd0);
         if (bus.o_done) begin
            if (sb_q.size() == 0) begin
               chk("unexpected_done", 200'd1, 200'd0);
            end else begin
               e = sb_q.pop_front();
               chk("c_flat", bus.o_c_flat, e.c);
               chk("overflow", 200'(bus.o_overflow_flag), 200'(e.ovf));
               chk("done_cycle", 200'(cyc), 200'(e.cyc));
               chk("busy_cycles", 200'(busy_run), 200'd25);
            end
            busy_run = 0;
         end else if (bus.o_busy) begin
            busy_run++;
         end else begin
            busy_run = 0;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   initial begin
      logic [199:0] a, b, c, id_m, b_m;
      logic         o;
      bus.i_start  = 1'b0;
      bus.i_abort  = 1'b0;
      bus.i_a_flat = '0;
      bus.i_b_flat = '0;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", 200'(bus.o_busy), 200'd0);
      chk("rst_done", 200'(bus.o_done), 200'd0);
      chk("rst_c", bus.o_c_flat, 200'd0);
      chk("rst_ovf", 200'(bus.o_overflow_flag), 200'd0);
      rst = 1'b0;
      step(1'b0, '0, '0);

      // Identity times a ramp.
      id_m = '0;
      for (int r = 0; r < 5; r++) id_m[r*40 + r*8 +: 8] = 8'd1;
      for (int e = 0; e < 25; e++) b_m[e*8 +: 8] = 8'(e - 12);
      step(1'b1, id_m, b_m);
      step(1'b0, id_m, b_m);
      drain();
      chk("identity_c_eq_b", bus.o_c_flat, b_m);

      // Sum saturation and overflow boundaries.
      step(1'b1, fill(8'd127), fill(8'd127));
      drain();
      chk("sat_pos_byte", 200'(bus.o_c_flat[7:0]), 200'h05);
      step(1'b1, fill(8'h80), fill(8'h80));
      drain();
      a = '0; b = '0; b[7:0] = 8'd64;
      a[7:0] = 8'd2;   step(1'b1, a, b); drain();
      a[7:0] = 8'hFE;  step(1'b1, a, b); drain();
      a[7:0] = 8'd1; b[7:0] = 8'd127; step(1'b1, a, b); drain();

      // start held for 40 cycles with operands changing every cycle.
      for (int n = 0; n < 40; n++) step(1'b1, rand_mat(n % 2), rand_mat(0));
      drain();

      // Random starts, operands churning throughout.
      for (int n = 0; n < 300; n++) begin
         step(($urandom_range(0, 3) == 0), rand_mat(int'($urandom_range(0, 1))), rand_mat(0));
      end
      drain();

      // Abort sampled at edge 10: elements 0..8 kept, no done.
      a = rand_mat(0);
      b = rand_mat(0);
      bus.i_start = 1'b1; bus.i_a_flat = a; bus.i_b_flat = b;
      @(posedge clk); #1;
      bus.i_start = 1'b0;
      bus.i_a_flat = rand_mat(0); bus.i_b_flat = rand_mat(0);
      repeat (9) begin @(posedge clk); #1; end
      chk("abort_busy_before", 200'(bus.o_busy), 200'd1);
      bus.i_abort = 1'b1;
      @(posedge clk); #1;
      bus.i_abort = 1'b0;
      chk("abort_busy_after", 200'(bus.o_busy), 200'd0);
      chk("abort_done", 200'(bus.o_done), 200'd0);
      ref_partial(a, b, 9, c, o);
      chk("abort_partial_c", bus.o_c_flat, c);
      chk("abort_partial_ovf", 200'(bus.o_overflow_flag), 200'(o));
      repeat (30) begin @(posedge clk); #1; end
      chk("abort_hold_c", bus.o_c_flat, c);
      free_at = 0;

      // Reset sampled at edge 12 mid-operation, then a clean multiply.
      bus.i_start = 1'b1; bus.i_a_flat = rand_mat(0); bus.i_b_flat = rand_mat(0);
      @(posedge clk); #1;
      bus.i_start = 1'b0;
      repeat (11) begin @(posedge clk); #1; end
      rst = 1'b1;
      @(posedge clk); #1;
      chk("midrst_busy", 200'(bus.o_busy), 200'd0);
      chk("midrst_done", 200'(bus.o_done), 200'd0);
      chk("midrst_c", bus.o_c_flat, 200'd0);
      chk("midrst_ovf", 200'(bus.o_overflow_flag), 200'd0);
      rst = 1'b0;
      free_at = 0;
      step(1'b1, rand_mat(0), rand_mat(0));
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
